alu_share_ctrl: RTL and testbench

Shares one 32-bit integer ALU (`alu_v1`) between up to four requesters, such as the execute stage, branch-compare logic and address generation. Round-robin arbitration grants one requester per cycle. The block has two registered stages (issue, response) with valid/ready handshakes on both sides and returns result, flags and an error indication to the requester that issued the operation. A free-running transaction counter supports performance monitoring.

---
 rtl/alu_share_ctrl_pkg.sv | 37 +++
 rtl/alu_share_ctrl_if.sv | 30 +++
 rtl/alu_share_ctrl_rr_arbiter.sv | 48 ++++
 rtl/alu_v1.sv | 41 ++++
 rtl/alu_share_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the shared-ALU controller.
//   alu_op_e        : ALU opcode encoding (10..14 are undefined)
//   alu_req_t       : operation held in the issue stage
//   alu_rsp_t       : result held in the response stage
//   ALU_DBG_PATTERN : fixed result returned by the debug opcode
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_DBG  = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        zero;
        logic        sign;
        logic        err;
    } alu_rsp_t;

    localparam logic [31:0] ALU_DBG_PATTERN = 32'hF7F7F7F7;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bus of the shared-ALU controller.
//   req_valid/req_ready/req_a/req_b/req_op : per-requester operation handshake
//   rsp_valid/rsp_ready                    : per-requester response handshake
//   rsp_data/rsp_zero/rsp_sign/rsp_err     : response payload, shared by all
// master = requester side, slave = controller side.
interface alu_share_ctrl_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_a;
    logic [NUM_REQ-1:0][31:0] req_b;
    logic [NUM_REQ-1:0][3:0]  req_op;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [31:0]              rsp_data;
    logic                     rsp_zero;
    logic                     rsp_sign;
    logic                     rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_sign, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_sign, rsp_err
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   req     : per-requester request
//   advance : the granted requester was accepted this cycle
//   grant   : one-hot, first requester at or after the pointer
// The pointer moves past the granted requester only on advance.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        idx   = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // Kept apart from the grant logic: advance is itself derived from grant.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) ptr_d = IW'((i + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/alu_v1.sv
// Combinational 32-bit integer ALU.
//   a, b         : operands (shifts use b[4:0])
//   op           : opcode (alu_op_e encoding)
//   out          : result; 0 for undefined opcodes
//   zero_flag    : out == 0
//   sign_flag    : out[31]
//   error_vector : one bit per undefined opcode 10..14
module alu_v1
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] out,
    output logic        zero_flag,
    output logic        sign_flag,
    output logic [4:0]  error_vector
);
    always_comb begin
        out          = '0;
        error_vector = '0;
        case (op)
            ALU_ADD:  out = a + b;
            ALU_SUB:  out = a - b;
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_XOR:  out = a ^ b;
            ALU_SLL:  out = a << b[4:0];
            ALU_SRL:  out = a >> b[4:0];
            ALU_SRA:  out = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  out = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: out = {31'd0, a < b};
            ALU_DBG:  out = ALU_DBG_PATTERN;
            // Only 10..14 reach here; flag the offending opcode.
            default:  error_vector = 5'b00001 << (op - 4'd10);
        endcase
    end

    assign zero_flag = (out == 32'd0);
    assign sign_flag = out[31];
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NUM_REQ requesters through a two-stage pipeline.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : requester bus (slave side)
//   busy      : issue or response stage occupied
//   txn_count : completed response handshakes, wraps at 16 bits
// Issue stage holds the granted operation and feeds the ALU; the response
// stage captures the ALU result. A stalled response freezes both stages.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_ctrl_if.slave bus,
    output logic            busy,
    output logic [15:0]     txn_count
);
    localparam int IW = $clog2(NUM_REQ);

    logic               iss_valid_q, iss_valid_d;
    logic [IW-1:0]      iss_owner_q, iss_owner_d;
    alu_req_t           iss_req_q, iss_req_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]      rsp_owner_q, rsp_owner_d;
    alu_rsp_t           rsp_q, rsp_d;
    logic [15:0]        txn_q, txn_d;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               stall;
    logic               accept;
    logic               rsp_fire;

    logic [31:0]        alu_out;
    logic               zero_flag;
    logic               sign_flag;
    logic [4:0]         error_vector;

    assign stall    = rsp_valid_q & ~bus.rsp_ready[rsp_owner_q];
    assign rsp_fire = rsp_valid_q & bus.rsp_ready[rsp_owner_q];
    assign accept   = |(bus.req_valid & bus.req_ready);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    alu_v1 u_alu (
        .a            (iss_req_q.a),
        .b            (iss_req_q.b),
        .op           (iss_req_q.op),
        .out          (alu_out),
        .zero_flag    (zero_flag),
        .sign_flag    (sign_flag),
        .error_vector (error_vector)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = IW'(i);
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_owner_d = iss_owner_q;
        iss_req_d   = iss_req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_owner_d = rsp_owner_q;
        rsp_d       = rsp_q;
        txn_d       = txn_q;

        // Not stalled means the response slot is empty or draining this
        // cycle, so the issue stage always moves forward.
        if (!stall) begin
            iss_valid_d = accept;
            if (accept) begin
                iss_owner_d  = grant_idx;
                iss_req_d.a  = bus.req_a[grant_idx];
                iss_req_d.b  = bus.req_b[grant_idx];
                iss_req_d.op = bus.req_op[grant_idx];
            end
            rsp_valid_d = iss_valid_q;
            if (iss_valid_q) begin
                rsp_owner_d = iss_owner_q;
                rsp_d.data  = alu_out;
                rsp_d.zero  = zero_flag;
                rsp_d.sign  = sign_flag;
                rsp_d.err   = |error_vector;
            end
        end

        if (rsp_fire) txn_d = txn_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_owner_q <= '0;
            iss_req_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= '0;
            rsp_q       <= '0;
            txn_q       <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_owner_q <= iss_owner_d;
            iss_req_q   <= iss_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_q       <= rsp_d;
            txn_q       <= txn_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (!rst && !stall) bus.req_ready = grant;
        bus.rsp_valid = '0;
        if (rsp_valid_q) bus.rsp_valid[rsp_owner_q] = 1'b1;
        bus.rsp_data = rsp_q.data;
        bus.rsp_zero = rsp_q.zero;
        bus.rsp_sign = rsp_q.sign;
        bus.rsp_err  = rsp_q.err;
    end

    assign busy      = iss_valid_q | rsp_valid_q;
    assign txn_count = txn_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with two requesters. Accepted operations
// push their expected response into a queue; response handshakes pop it.
module tb_alu_share_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] txn_count;

    always #5 clk = ~clk;

    alu_share_ctrl_if #(.NUM_REQ(2)) bus ();

    alu_share_ctrl #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .txn_count (txn_count)
    );

    logic [36:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_txn = 16'd0;
    int          pops_since_rst = 0;
    bit          auto_refill = 1'b0;
    int          push_left = 0;
    bit          check_alt = 1'b0;
    int          alt_exp = 0;
    logic [31:0] hold_data;
    logic [1:0]  hold_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference ALU: {data, zero, sign, err}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [31:0] d;
        logic        e;
        logic [4:0]  sh;
        d  = 32'd0;
        e  = 1'b0;
        sh = b[4:0];
        case (op)
            4'd0:  d = a + b;
            4'd1:  d = a + ~b + 32'd1;
            4'd2:  d = a & b;
            4'd3:  d = a | b;
            4'd4:  d = a ^ b;
            4'd5:  d = a << sh;
            4'd6:  d = a >> sh;
            4'd7:  d = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            4'd8:  d = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
            4'd9:  d = (a < b) ? 32'd1 : 32'd0;
            4'd15: d = 32'hF7F7F7F7;
            default: e = 1'b1;
        endcase
        return {d, d == 32'd0, d[31], e};
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        bus.req_a[i[0]]     = a;
        bus.req_b[i[0]]     = b;
        bus.req_op[i[0]]    = op;
        bus.req_valid[i[0]] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        set_req(i, $urandom, (($urandom & 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                4'($urandom_range(0, 15)));
    endtask

    // One clock: monitor at the falling edge, then refill inputs after the rising edge.
    task automatic step();
        logic [1:0] acc;
        logic [1:0] oh;
        @(negedge clk);
        chk("busy", 64'(busy), 64'(sb.size() != 0));
        chk("txn_count", 64'(txn_count), 64'(exp_txn));
        chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'(1));
        acc = bus.req_valid & bus.req_ready;
        for (int i = 0; i < 2; i++) begin
            if (acc[i[0]]) begin
                oh = (i == 0) ? 2'b01 : 2'b10;
                sb.push_back({oh, model(bus.req_a[i[0]], bus.req_b[i[0]], bus.req_op[i[0]])});
                if (check_alt) begin
                    chk("rr_grant", 64'(i), 64'(alt_exp));
                    alt_exp = 1 - i;
                end
            end
        end
        if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                chk("sb_pop_empty", 64'(sb.size()), 64'(1));
            end else begin
                chk("rsp", 64'({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_sign, bus.rsp_err}),
                    64'(sb.pop_front()));
            end
            exp_txn = exp_txn + 16'd1;
            pops_since_rst++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i[0]]) begin
                if (auto_refill && push_left > 0) begin
                    rand_req(i);
                    push_left--;
                end else begin
                    bus.req_valid[i[0]] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (sb.size() != 0 || bus.req_valid != 2'b00); k++) step();
        chk("drain_done", 64'(sb.size() == 0 && bus.req_valid == 2'b00), 64'(1));
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_data", 64'({bus.rsp_data, bus.rsp_zero, bus.rsp_sign, bus.rsp_err}), 64'(0));
        chk("rst_txn", 64'(txn_count), 64'(0));
        bus.req_valid = 2'b00;
        rst = 1'b0;

        // Single op, 2-cycle latency: 5 - 3 = 2
        set_req(0, 32'd5, 32'd3, 4'd1);
        step();
        chk("lat_n1_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("lat_n1_busy", 64'(busy), 64'(1));
        step();
        chk("lat_n2_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
        chk("lat_n2_payload", 64'({bus.rsp_data, bus.rsp_zero, bus.rsp_sign, bus.rsp_err}),
            64'({32'd2, 1'b0, 1'b0, 1'b0}));
        step();
        chk("lat_txn", 64'(txn_count), 64'(1));
        chk("lat_no_dup", 64'(bus.rsp_valid), 64'(0));

        // Both requesters streaming; pointer sits at 1 after the req0 grant
        auto_refill = 1'b1;
        push_left   = 6;
        check_alt   = 1'b1;
        alt_exp     = 1;
        rand_req(0);
        rand_req(1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k >= 2 && k <= 9) chk("stream_rsp_each_cycle", 64'(bus.rsp_valid != 2'b00), 64'(1));
        end
        check_alt = 1'b0;
        drain();

        // Stall with both stages full: sra, debug, then an undefined opcode waiting
        auto_refill   = 1'b0;
        bus.rsp_ready = 2'b00;
        set_req(1, 32'h80000000, 32'h24, 4'd7);
        set_req(0, 32'h12345678, 32'h0, 4'd15);
        step();
        step();
        chk("stall_busy", 64'(busy), 64'(1));
        set_req(1, 32'd7, 32'd9, 4'd12);
        hold_data  = bus.rsp_data;
        hold_valid = bus.rsp_valid;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
            chk("stall_data_stable", 64'(bus.rsp_data), 64'(hold_data));
            chk("stall_valid_stable", 64'(bus.rsp_valid), 64'(hold_valid));
        end
        bus.rsp_ready = 2'b11;
        drain();

        // Asynchronous reset with both stages full
        bus.rsp_ready = 2'b00;
        auto_refill   = 1'b1;
        push_left     = 100;
        rand_req(0);
        rand_req(1);
        repeat (3) step();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("arst_txn", 64'(txn_count), 64'(0));
        chk("arst_payload", 64'({bus.rsp_data, bus.rsp_zero, bus.rsp_sign, bus.rsp_err}), 64'(0));
        sb.delete();
        exp_txn        = 16'd0;
        pops_since_rst = 0;
        step();
        #2;
        rst = 1'b0;
        #1;
        bus.rsp_ready = 2'b11;
        chk("post_rst_grant", 64'(bus.req_ready), 64'(2'b01));
        chk("post_rst_txn", 64'(txn_count), 64'(0));

        // 65536 responses wrap the counter back to zero
        push_left = 70000;
        for (int k = 0; k < 70000 && pops_since_rst < 65536; k++) step();
        chk("wrap_pops", 64'(pops_since_rst), 64'(65536));
        chk("wrap_txn", 64'(txn_count), 64'(16'h0000));
        push_left = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
